// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART TX drain and the future RX stage.
// Contents:
//   DATA_W               - UART payload width (8)
//   DEFAULT_CLKS_PER_BIT - 100 MHz / 115200 baud
//   uart_state_t         - frame sequencer state encoding
//   even_parity()        - XOR reduction of one payload word
package uart_pkg;

  localparam int DATA_W               = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } uart_state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps, so every bit
// lasts exactly CLKS_PER_BIT cycles.
// Ports:
//   clk         in  system clock, rising edge
//   rst         in  asynchronous active-high reset
//   clear       in  forces the count to 0 on the next edge
//   bit_end     out high in the last cycle of a bit period
//   bit_pre_end out high in the second-to-last cycle of a bit period
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end,
  output logic bit_pre_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end     = (cnt == LAST);
  // Lets the sequencer register byte_done one cycle ahead so it lands
  // in the final cycle of the stop bit.
  assign bit_pre_end = (cnt == PRE_LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// uart_tx_drain
// Pops bytes from the byte FIFO (rd_en / empty / registered data_out) and
// serialises them on the TX pin, LSB first, 8N1 or 8N2.
// Optional build macro: PARITY_EN adds an even-parity bit (8E1 / 8E2).
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   enable      in   1 = fetch new bytes; 0 = finish current frame then idle
//   fifo_empty  in   FIFO empty flag
//   fifo_data   in   FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  single-cycle pop request
//   tx          out  serial line, idles high
//   busy        out  high from the pop cycle through the last stop-bit cycle
//   byte_done   out  one-cycle pulse in the last cycle of the final stop bit
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              byte_done
);

  uart_state_t       state;
  logic [DATA_W-1:0] shift_reg;
  logic [2:0]        bit_idx;
  logic              stop_idx;
  logic              busy_q;
  logic              bit_end;
  logic              bit_pre_end;
  logic              cnt_clear;
  logic              last_stop;
`ifdef PARITY_EN
  logic              parity_bit;
`endif

  // Clearing during FETCH puts the counter at 0 in the first START cycle.
  assign cnt_clear = (state == FETCH);

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .bit_end    (bit_end),
    .bit_pre_end(bit_pre_end)
  );

  // The pop is decided in IDLE from the live flags so the FIFO word is
  // ready in FETCH; gating with rst keeps the FIFO untouched during reset.
  assign fifo_rd_en = ~rst & (state == IDLE) & enable & ~fifo_empty;

  // busy_q covers FETCH..STOP; the pop cycle itself is covered by the
  // pop request so busy spans the whole transaction.
  assign busy = busy_q | fifo_rd_en;

  assign last_stop = (stop_idx == 1'(STOP_BITS - 1));

  // tx is always loaded one edge early so it changes exactly on bit
  // boundaries; shift_reg holds the bits still to be sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      busy_q     <= 1'b0;
      byte_done  <= 1'b0;
      shift_reg  <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
`ifdef PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_rd_en) begin
            state  <= FETCH;
            busy_q <= 1'b1;
          end
        end

        FETCH: begin
          shift_reg  <= fifo_data;
`ifdef PARITY_EN
          parity_bit <= even_parity(fifo_data);
`endif
          tx         <= 1'b0;
          state      <= START;
        end

        START: begin
          if (bit_end) begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_idx   <= '0;
            state     <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
`ifdef PARITY_EN
              tx      <= parity_bit;
              state   <= PARITY;
`else
              tx       <= 1'b1;
              stop_idx <= 1'b0;
              state    <= STOP;
`endif
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end

`ifdef PARITY_EN
        PARITY: begin
          if (bit_end) begin
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= STOP;
          end
        end
`endif

        STOP: begin
          if (bit_pre_end && last_stop) begin
            byte_done <= 1'b1;
          end
          if (bit_end) begin
            if (last_stop) begin
              busy_q <= 1'b0;
              state  <= IDLE;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end

        default: begin
          tx     <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
